// File: rtl/sharp_coef_sched_pkg.sv
// sharp_coef_sched_pkg: shared register map, CTRL bit positions and FSM encoding
package sharp_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_COEF   = 2'd1;
  localparam logic [1:0] REG_WIDTH  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_t;
endpackage

// File: rtl/sharp_coef_sched_if.sv
// sharp_coef_sched_if: CPU register bus plus snooped filter input handshake
interface sharp_coef_sched_if;
  logic        reg_wr;
  logic        reg_rd;
  logic [1:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic        mon_val;
  logic        mon_rdy;
  logic        mon_sof;
  logic        mon_eof;
  logic        mon_sol;
  logic        mon_eol;
  modport master (output reg_wr, reg_rd, reg_addr, reg_wdata, mon_val, mon_rdy, mon_sof, mon_eof, mon_sol, mon_eol, input reg_rdata);
  modport slave (input reg_wr, reg_rd, reg_addr, reg_wdata, mon_val, mon_rdy, mon_sof, mon_eof, mon_sol, mon_eol, output reg_rdata);
endinterface

// File: rtl/sharp_coef_sched_line_chk.sv
// sharp_line_chk: per-line pixel counting, line counting and sticky line-length error
module sharp_line_chk #(
  parameter int CNT_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 beat,
  input  logic                 restart,
  input  logic                 eol,
  input  logic                 sol,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] width,
  output logic                 err_len,
  output logic                 sol_bad,
  output logic [CNT_WIDTH-1:0] line_nx
);
  localparam logic [CNT_WIDTH-1:0] MAX = '1;
  logic [CNT_WIDTH-1:0] px_q, px_d, line_q, line_d, px_eff, line_eff;
  logic [CNT_WIDTH:0]   px_inc;
  logic                 err_len_q, err_len_d;
  // a sof beat counts from cleared counters, so it is pixel 0 of line 0
  always_comb begin
    px_eff    = restart ? '0 : px_q;
    line_eff  = restart ? '0 : line_q;
    px_inc    = {1'b0, px_eff} + (CNT_WIDTH+1)'(1);
    line_nx   = (beat & eol & (line_eff != MAX)) ? line_eff + CNT_WIDTH'(1) : line_eff;
    px_d      = !beat ? px_q : eol ? '0 : (px_eff == MAX) ? MAX : px_eff + CNT_WIDTH'(1);
    line_d    = beat ? line_nx : line_q;
    err_len_d = (beat & eol & (width != '0) & (px_inc != {1'b0, width})) | (err_len_q & ~clr);
    sol_bad   = beat & sol & (px_eff != '0);
  end
  // counter and error state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q      <= '0;
      line_q    <= '0;
      err_len_q <= 1'b0;
    end else begin
      px_q      <= px_d;
      line_q    <= line_d;
      err_len_q <= err_len_d;
    end
  end
  assign err_len = err_len_q;
endmodule

// File: rtl/sharp_coef_sched.sv
// sharp_coef_sched: frame-synchronous coefficient commit, framing checks and frame counting
module sharp_coef_sched
  import sharp_pkg::*;
#(
  parameter int COEF_WIDTH = 8,
  parameter int CNT_WIDTH  = 12,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  sharp_coef_sched_if.slave     bus,
  output logic [COEF_WIDTH-1:0] cfg_coef,
  output logic                  busy,
  output logic [FCNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0]  lines_last,
  output logic                  err_sync,
  output logic                  err_len
);
  state_t                state_q, state_d;
  logic                  pending_q, pending_d, shadow_en_q, shadow_en_d, active_en_q, active_en_d;
  logic [COEF_WIDTH-1:0] shadow_coef_q, shadow_coef_d, active_coef_q, active_coef_d;
  logic [CNT_WIDTH-1:0]  shadow_width_q, shadow_width_d, active_width_q, active_width_d;
  logic [CNT_WIDTH-1:0]  lines_last_q, lines_last_d, line_nx;
  logic [FCNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [15:0]           rdata_q, rdata_d;
  logic                  err_sync_q, err_sync_d;
  logic                  beat, idle, in_frame, eof_b, sof_b, clr, commit, sol_bad;
  logic                  wr_ctrl, wr_coef, wr_width, wr_any;
  assign beat     = bus.mon_val & bus.mon_rdy;
  assign idle     = state_q == IDLE;
  assign sof_b    = beat & bus.mon_sof;
  assign in_frame = beat & (~idle | bus.mon_sof);
  assign eof_b    = in_frame & bus.mon_eof;
  assign wr_ctrl  = bus.reg_wr & (bus.reg_addr == REG_CTRL);
  assign wr_coef  = bus.reg_wr & (bus.reg_addr == REG_COEF);
  assign wr_width = bus.reg_wr & (bus.reg_addr == REG_WIDTH);
  assign wr_any   = wr_ctrl | wr_coef | wr_width;
  assign clr      = wr_ctrl & bus.reg_wdata[CTRL_CLR];
  assign commit   = idle & pending_q;
  sharp_line_chk #(.CNT_WIDTH(CNT_WIDTH)) u_line_chk (
    .clk(clk), .rst(rst), .beat(in_frame), .restart(sof_b), .eol(bus.mon_eol), .sol(bus.mon_sol),
    .clr(clr), .width(active_width_q), .err_len(err_len), .sol_bad(sol_bad), .line_nx(line_nx)
  );
  // next-state: framing FSM, shadow/active registers with between-frame commit, counters, read mux
  always_comb begin
    state_d        = eof_b ? IDLE : in_frame ? FRAME : state_q;
    pending_d      = wr_any | (pending_q & ~commit);
    shadow_en_d    = wr_ctrl ? bus.reg_wdata[CTRL_EN] : shadow_en_q;
    shadow_coef_d  = wr_coef ? bus.reg_wdata[COEF_WIDTH-1:0] : shadow_coef_q;
    shadow_width_d = wr_width ? bus.reg_wdata[CNT_WIDTH-1:0] : shadow_width_q;
    active_en_d    = commit ? shadow_en_q : active_en_q;
    active_coef_d  = commit ? shadow_coef_q : active_coef_q;
    active_width_d = commit ? shadow_width_q : active_width_q;
    err_sync_d     = (beat & idle & ~bus.mon_sof) | (beat & ~idle & bus.mon_sof & ~bus.mon_eof) | sol_bad | (err_sync_q & ~clr);
    frame_cnt_d    = eof_b ? (clr ? FCNT_WIDTH'(1) : frame_cnt_q + FCNT_WIDTH'(1)) : clr ? '0 : frame_cnt_q;
    lines_last_d   = eof_b ? line_nx : clr ? '0 : lines_last_q;
    rdata_d        = !bus.reg_rd ? rdata_q :
                     (bus.reg_addr == REG_CTRL)  ? {13'b0, ~idle, pending_q, shadow_en_q} :
                     (bus.reg_addr == REG_COEF)  ? 16'(shadow_coef_q) :
                     (bus.reg_addr == REG_WIDTH) ? 16'(shadow_width_q) : {14'b0, err_len, err_sync_q};
  end
  // all controller state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pending_q      <= 1'b0;
      shadow_en_q    <= 1'b0;
      shadow_coef_q  <= '0;
      shadow_width_q <= '0;
      active_en_q    <= 1'b0;
      active_coef_q  <= '0;
      active_width_q <= '0;
      err_sync_q     <= 1'b0;
      frame_cnt_q    <= '0;
      lines_last_q   <= '0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      shadow_en_q    <= shadow_en_d;
      shadow_coef_q  <= shadow_coef_d;
      shadow_width_q <= shadow_width_d;
      active_en_q    <= active_en_d;
      active_coef_q  <= active_coef_d;
      active_width_q <= active_width_d;
      err_sync_q     <= err_sync_d;
      frame_cnt_q    <= frame_cnt_d;
      lines_last_q   <= lines_last_d;
      rdata_q        <= rdata_d;
    end
  end
  assign cfg_coef      = active_en_q ? active_coef_q : '0;
  assign busy          = ~idle;
  assign frame_cnt     = frame_cnt_q;
  assign lines_last    = lines_last_q;
  assign err_sync      = err_sync_q;
  assign bus.reg_rdata = rdata_q;
endmodule

// File: tb/tb_sharp_coef_sched.sv
// tb_sharp_coef_sched: directed and randomized checks of sharp_coef_sched against a behavioural model
module tb_sharp_coef_sched;
  localparam int CMAX = 4095;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  sharp_coef_sched_if bus();
  logic [7:0]  cfg_coef;
  logic        busy, err_sync, err_len;
  logic [15:0] frame_cnt;
  logic [11:0] lines_last;
  sharp_coef_sched #(.COEF_WIDTH(8), .CNT_WIDTH(12), .FCNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .cfg_coef(cfg_coef), .busy(busy), .frame_cnt(frame_cnt),
    .lines_last(lines_last), .err_sync(err_sync), .err_len(err_len)
  );
  int checks = 0;
  int errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // behavioural model: integers for counts, a frame-open flag, shadow and active settings
  bit        m_frame, m_es, m_el, m_pend, s_en, a_en;
  int        m_px, m_line, m_ll, s_coef, s_w, a_coef, a_w;
  bit [15:0] m_fcnt, m_rd;
  bit        b_beat, b_sof, b_eof, b_sol, b_eol, b_clr, es_set, el_set, inc, commit;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_frame = 0; m_es = 0; m_el = 0; m_pend = 0; s_en = 0; a_en = 0;
      m_px = 0; m_line = 0; m_ll = 0; s_coef = 0; s_w = 0; a_coef = 0; a_w = 0;
      m_fcnt = 0; m_rd = 0;
    end else begin
      b_beat = bus.mon_val && bus.mon_rdy;
      b_sof = bus.mon_sof; b_eof = bus.mon_eof; b_sol = bus.mon_sol; b_eol = bus.mon_eol;
      b_clr = bus.reg_wr && bus.reg_addr == 2'd0 && bus.reg_wdata[1];
      es_set = 0; el_set = 0; inc = 0;
      commit = !m_frame && m_pend;
      if (bus.reg_rd)
        case (bus.reg_addr)
          2'd0: m_rd = {13'b0, m_frame, m_pend, s_en};
          2'd1: m_rd = 16'(s_coef);
          2'd2: m_rd = 16'(s_w);
          default: m_rd = {14'b0, m_el, m_es};
        endcase
      if (b_beat) begin
        if (!m_frame && !b_sof) es_set = 1;
        else begin
          if (b_sof) begin
            if (m_frame && !b_eof) es_set = 1;
            m_px = 0; m_line = 0;
          end
          if (b_sol && m_px != 0) es_set = 1;
          if (b_eol) begin
            if (a_w != 0 && m_px + 1 != a_w) el_set = 1;
            m_px = 0;
            m_line = (m_line < CMAX) ? m_line + 1 : CMAX;
          end else m_px = (m_px < CMAX) ? m_px + 1 : CMAX;
          if (b_eof) begin inc = 1; m_ll = m_line; end
          m_frame = !b_eof;
        end
      end
      m_es = es_set || (m_es && !b_clr);
      m_el = el_set || (m_el && !b_clr);
      m_fcnt = b_clr ? 16'(inc) : m_fcnt + 16'(inc);
      if (b_clr && !inc) m_ll = 0;
      if (commit) begin a_en = s_en; a_coef = s_coef; a_w = s_w; end
      if (bus.reg_wr)
        case (bus.reg_addr)
          2'd0: s_en = bus.reg_wdata[0];
          2'd1: s_coef = int'(bus.reg_wdata[7:0]);
          2'd2: s_w = int'(bus.reg_wdata[11:0]);
          default: ;
        endcase
      m_pend = (bus.reg_wr && bus.reg_addr != 2'd3) || (m_pend && !commit);
    end
  end
  // every cycle: all outputs against the model, away from the clock edge
  always @(negedge clk) begin
    chk("cfg_coef", 32'(cfg_coef), a_en ? 32'(a_coef) : 32'd0);
    chk("busy", 32'(busy), 32'(m_frame));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    chk("lines_last", 32'(lines_last), 32'(m_ll));
    chk("err_sync", 32'(err_sync), 32'(m_es));
    chk("err_len", 32'(err_len), 32'(m_el));
    chk("reg_rdata", 32'(bus.reg_rdata), 32'(m_rd));
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic wr(input int a, input int d);
    bus.reg_wr = 1; bus.reg_addr = a[1:0]; bus.reg_wdata = d[15:0];
    tick;
    bus.reg_wr = 0;
  endtask
  task automatic rd(input int a);
    bus.reg_rd = 1; bus.reg_addr = a[1:0];
    tick;
    bus.reg_rd = 0;
  endtask
  task automatic pix(input bit sof, input bit eof, input bit sol, input bit eol, input int stall);
    int n = 0;
    bus.mon_val = 1; bus.mon_sof = sof; bus.mon_eof = eof; bus.mon_sol = sol; bus.mon_eol = eol;
    do begin
      bus.mon_rdy = (n >= 40) || ($urandom_range(99) >= stall);
      n++;
      tick;
    end while (!bus.mon_rdy);
    bus.mon_val = 0; bus.mon_sof = 0; bus.mon_eof = 0; bus.mon_sol = 0; bus.mon_eol = 0;
    bus.mon_rdy = 1'($urandom);
  endtask
  bit done = 0;
  initial begin
    bus.reg_wr = 0; bus.reg_rd = 0; bus.reg_addr = 0; bus.reg_wdata = 0;
    bus.mon_val = 0; bus.mon_rdy = 0; bus.mon_sof = 0; bus.mon_eof = 0; bus.mon_sol = 0; bus.mon_eol = 0;
    #1 rst = 1;
    repeat (3) tick;
    rst = 0;
    chk("reset cfg_coef", 32'(cfg_coef), 0);
    chk("reset frame_cnt", 32'(frame_cnt), 0);
    chk("reset busy", 32'(busy), 0);
    // idle commit of coefficient then enable
    wr(1, 'h40); wr(0, 1); tick; tick;
    chk("idle commit", 32'(cfg_coef), 'h40);
    rd(0);
    chk("ctrl readback", 32'(bus.reg_rdata), 'h0001);
    // 4x2 frame with a mid-frame coefficient write
    pix(1, 0, 1, 0, 0); pix(0, 0, 0, 0, 0);
    wr(1, 'h80);
    chk("hold mid-frame", 32'(cfg_coef), 'h40);
    pix(0, 0, 0, 0, 0); pix(0, 0, 0, 1, 0);
    pix(0, 0, 1, 0, 0); pix(0, 0, 0, 0, 0); pix(0, 0, 0, 0, 0); pix(0, 1, 0, 1, 0);
    chk("hold at eof", 32'(cfg_coef), 'h40);
    tick;
    chk("commit after frame", 32'(cfg_coef), 'h80);
    chk("frame_cnt 1", 32'(frame_cnt), 1);
    chk("lines_last 2", 32'(lines_last), 2);
    // short line against width 4, then clear
    wr(2, 4); tick;
    pix(1, 0, 1, 0, 0); pix(0, 0, 0, 0, 0); pix(0, 0, 0, 1, 0);
    pix(0, 0, 1, 0, 0); pix(0, 0, 0, 0, 0); pix(0, 0, 0, 0, 0); pix(0, 1, 0, 1, 0);
    chk("err_len set", 32'(err_len), 1);
    chk("frame_cnt 2", 32'(frame_cnt), 2);
    wr(0, 3);
    chk("err_len cleared", 32'(err_len), 0);
    chk("frame_cnt cleared", 32'(frame_cnt), 0);
    // sync errors: stray beat in idle, second sof mid-frame
    pix(0, 0, 0, 0, 0);
    chk("stray beat err_sync", 32'(err_sync), 1);
    chk("stray beat idle", 32'(busy), 0);
    wr(0, 3);
    chk("err_sync cleared", 32'(err_sync), 0);
    pix(1, 0, 1, 0, 0); pix(0, 0, 0, 0, 0); pix(1, 0, 1, 0, 0);
    chk("mid sof err_sync", 32'(err_sync), 1);
    chk("mid sof stays frame", 32'(busy), 1);
    pix(0, 1, 0, 1, 0);
    chk("frame closed", 32'(busy), 0);
    wr(0, 3);
    // stalled handshake does not move the FSM
    bus.mon_val = 1; bus.mon_sof = 1; bus.mon_sol = 1; bus.mon_rdy = 0;
    tick; tick; tick;
    chk("stalled sof", 32'(busy), 0);
    bus.mon_rdy = 1; tick;
    chk("sof beat", 32'(busy), 1);
    bus.mon_sof = 0; bus.mon_sol = 0; bus.mon_eof = 1; bus.mon_eol = 1; bus.mon_rdy = 0;
    tick; tick;
    chk("stalled eof", 32'(busy), 1);
    bus.mon_rdy = 1; tick;
    chk("eof beat", 32'(busy), 0);
    bus.mon_val = 0; bus.mon_eof = 0; bus.mon_eol = 0;
    tick; tick;
    // write landing on the commit edge
    wr(1, 'h11); wr(1, 'h22);
    chk("commit pre-write", 32'(cfg_coef), 'h11);
    tick;
    chk("commit next idle", 32'(cfg_coef), 'h22);
    // saturated pixel counter against the largest width
    wr(2, CMAX); tick;
    pix(1, 0, 1, 0, 0);
    for (int i = 0; i < CMAX + 3; i++) pix(0, 0, 0, 0, 0);
    pix(0, 1, 0, 1, 0);
    chk("saturated err_len", 32'(err_len), 1);
    wr(0, 3); wr(2, 0);
    // reset in the middle of a frame
    wr(1, 'h40); tick; tick;
    chk("coef before reset", 32'(cfg_coef), 'h40);
    pix(1, 0, 1, 0, 0); pix(0, 0, 0, 0, 0);
    chk("busy before reset", 32'(busy), 1);
    rst = 1;
    #1;
    chk("async cfg_coef", 32'(cfg_coef), 0);
    chk("async busy", 32'(busy), 0);
    chk("async frame_cnt", 32'(frame_cnt), 0);
    tick; rst = 0; tick;
    pix(1, 0, 1, 0, 0);
    chk("clean sof", 32'(busy), 1);
    pix(0, 1, 0, 1, 0);
    chk("clean frame_cnt", 32'(frame_cnt), 1);
    chk("clean lines_last", 32'(lines_last), 1);
    chk("clean err_sync", 32'(err_sync), 0);
    // randomized frames with concurrent register traffic
    fork
      begin
        for (int f = 0; f < 150; f++) begin
          int w, h;
          w = $urandom_range(1, 5);
          h = $urandom_range(1, 3);
          for (int l = 0; l < h; l++)
            for (int p = 0; p < w; p++) begin
              bit sof, eof, eol;
              sof = (l == 0 && p == 0);
              eof = (l == h - 1 && p == w - 1);
              eol = (p == w - 1);
              if ($urandom_range(99) < 3) eol = !eol;
              if ($urandom_range(99) < 2) sof = !sof;
              pix(sof, eof, p == 0, eol, 25);
              repeat ($urandom_range(0, 2)) tick;
            end
        end
        done = 1;
      end
      begin
        while (!done) begin
          int r, a, d;
          r = $urandom_range(99);
          a = $urandom_range(0, 3);
          d = int'($urandom & 32'hffff);
          if (a == 0) d = ($urandom_range(9) == 0) ? (d | 2) : (d & ~2);
          if (a == 2) d = ($urandom_range(1) == 0) ? $urandom_range(0, 5) : d;
          if (r < 6) wr(a, d);
          else if (r < 20) rd(a);
          else tick;
        end
      end
    join
    tick; tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sharp_coef_sched.md
Name: sharp_coef_sched

Overview:
Frame-synchronous configuration controller for the sharpening filter. It holds CPU-written shadow registers (enable, coefficient, expected line width) and snoops the filter's 3x3 input handshake. It commits shadow values to the filter's cfg_coef only between frames, so a frame is never processed with mixed coefficients. It also checks frame and line framing, and counts frames.

Parameters:
COEF_WIDTH, 8, width of the sharpening coefficient driven to the filter
CNT_WIDTH, 12, width of the pixel, line and configured-width counters
FCNT_WIDTH, 16, width of the frame counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
reg_wr  in  1  register write strobe, one cycle per write
reg_rd  in  1  register read strobe
reg_addr  in  2  register address: 0 CTRL, 1 COEF, 2 WIDTH, 3 STATUS
reg_wdata  in  16  write data
reg_rdata  out  16  read data, registered
mon_val  in  1  filter input valid (snooped)
mon_rdy  in  1  filter input ready (snooped)
mon_sof  in  1  start of frame
mon_eof  in  1  end of frame
mon_sol  in  1  start of line
mon_eol  in  1  end of line
cfg_coef  out  COEF_WIDTH  coefficient to filter: active_coef if active_en, else 0 (pass-through)
busy  out  1  high while a frame is in progress (state FRAME)
frame_cnt  out  FCNT_WIDTH  completed frames, wraps at all-ones to 0
lines_last  out  CNT_WIDTH  line count of the last completed frame
err_sync  out  1  sticky framing error
err_len  out  1  sticky line-length error

Behaviour:
- Beat: mon_val & mon_rdy in a cycle. All monitoring acts on beats only.
- Reset values: all outputs, counters and registers are 0; state is IDLE; pending is 0; shadow width is 0.
- Register writes:
  - CTRL: bit0 shadow_en; bit1 clr, self-clearing, clears err_sync, err_len, frame_cnt and lines_last.
  - COEF: bits[COEF_WIDTH-1:0] shadow_coef.
  - WIDTH: bits[CNT_WIDTH-1:0] shadow_width.
  - STATUS: read-only; writes are ignored.
  - Any CTRL, COEF or WIDTH write sets pending.
- Register reads: reg_rdata updates on the clock edge after reg_rd (1-cycle latency) and otherwise holds.
  - 0: {13'b0, busy, pending, shadow_en}
  - 1: shadow_coef, zero-extended
  - 2: shadow_width, zero-extended
  - 3: {14'b0, err_len, err_sync}
- FSM state IDLE:
  - A beat with sof goes to FRAME; px_cnt and line_cnt clear.
  - A beat without sof sets err_sync and stays in IDLE; the beat is ignored.
- FSM state FRAME:
  - A beat with eof goes to IDLE, increments frame_cnt, and loads lines_last with line_cnt+1 if that beat has eol, else line_cnt.
  - A beat with sof (no eof) sets err_sync, clears px_cnt and line_cnt, and stays in FRAME.
  - A beat with sof and eof together is a one-beat frame. From IDLE it goes to FRAME and straight back to IDLE; frame_cnt increments.
- Commit: while state is IDLE and pending=1, on the clock edge active_en, active_coef and active_width load from the shadows and pending clears.
  - Commit is allowed in the same cycle as a sof beat, so the new cfg_coef is visible from the next cycle.
  - Never commit while in FRAME.
- Write in the same cycle as a commit: the commit takes the pre-write shadow values and pending stays 1. The new value commits on the next IDLE cycle.
- Line check (FRAME only):
  - px_cnt increments per beat.
  - On an eol beat: if px_cnt+1 != active_width and active_width != 0, set err_len. Then px_cnt clears and line_cnt increments.
  - active_width = 0 disables the check.
  - px_cnt and line_cnt saturate at all-ones. A saturated px_cnt flags err_len at eol when checking is enabled.
- Sticky errors vs clr in the same cycle: the set wins. frame_cnt increment vs clr in the same cycle: the result is 1.
- sol is used only for diagnostics: a sol beat with px_cnt != 0 sets err_sync.
- Reset asserted mid-frame returns everything to reset values immediately. cfg_coef drops to 0 asynchronously.

Decomposition:
- Shared package sharp_pkg: register address constants (REG_CTRL=0, REG_COEF=1, REG_WIDTH=2, REG_STATUS=3), CTRL bit indices, FSM state encoding (IDLE, FRAME).
- One natural sub-module: sharp_line_chk (px_cnt, line_cnt, err_len generation), instantiated once.

Test Plan:
- Reset, write COEF=0x40 and CTRL=1 while IDLE -> cfg_coef=0x40 two cycles after the CTRL write; pending reads back 0.
- Start a 4x2 frame, write COEF=0x80 mid-frame -> cfg_coef stays 0x40 until the eof beat. It becomes 0x80 one cycle after the first IDLE cycle; frame_cnt=1, lines_last=2.
- WIDTH=4, send a line with eol on the 3rd beat -> err_len=1 and sticks. Write CTRL with bit1 set -> err_len=0 and frame_cnt=0.
- Beat without sof while IDLE, and a second sof mid-frame -> err_sync=1 in both cases. State remains FRAME after the mid-frame sof.
- Hold mon_rdy=0 with mon_val=1 across sof/eof -> no state change until a beat. Commit write coincident with the commit edge -> value applied one IDLE cycle later.
- Assert rst mid-frame with coef=0x40 active -> cfg_coef=0, busy=0, frame_cnt=0 immediately. The next sof starts a clean frame.
